// File: rtl/decode_queue.sv
// ============================================================================
// Module   : decode_queue (with decode_queue_pkg)
// Brief    : Instruction FIFO plus a registered RV32I/Zicsr decode stage.
//            Fetch and execute connect over valid/ready handshakes, and a
//            flush input empties the queue on a branch or trap redirect.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package decode_queue_pkg;
  // The order of this list is the decode priority order.
  typedef enum logic [5:0] {
    OP_NOP,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_FENCE, OP_ECALL, OP_EBREAK,
    OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI
  } op_e;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_e;

  // Control bundle. The flags say which register fields the instruction uses.
  typedef struct packed {
    op_e  op;
    logic rs1;
    logic rs2;
    logic rDinSrc;
    imm_e imm_sel;
  } Signal;

  localparam Signal IR_SIGNAL_NOP = '{op: OP_NOP, rs1: 1'b0, rs2: 1'b0,
                                      rDinSrc: 1'b0, imm_sel: IMM_NONE};
endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_pc,
  input  logic [WIDTH-1:0]           in_ir,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_pc,
  output logic [4:0]                 rs1,
  output logic [4:0]                 rs2,
  output logic [4:0]                 rd,
  output logic [WIDTH-1:0]           imm,
  output Signal                      signal,
  output logic                       illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_pc_mem [DEPTH];
  logic [WIDTH-1:0] r_ir_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;

  logic             w_push, w_out_free, w_empty, w_pop, w_bypass, w_fifo_wr, w_load;
  logic [CNT_W-1:0] w_count_next;
  logic [WIDTH-1:0] w_ld_pc, w_ld_ir, w_imm;
  logic [4:0]       w_rs1, w_rs2, w_rd;
  logic             w_ecall;
  op_e              w_op;
  Signal            w_sig;

  // Find the instruction by opcode and function fields. Words that match nothing decode to OP_NOP.
  function automatic op_e match_op(input logic [31:0] ir);
    op_e op;
    op = OP_NOP;
    case (ir[6:0])
      7'b0110011: case ({ir[31:25], ir[14:12]})
        10'b0000000_000: op = OP_ADD;   10'b0100000_000: op = OP_SUB;
        10'b0000000_001: op = OP_SLL;   10'b0000000_010: op = OP_SLT;
        10'b0000000_011: op = OP_SLTU;  10'b0000000_100: op = OP_XOR;
        10'b0000000_101: op = OP_SRL;   10'b0100000_101: op = OP_SRA;
        10'b0000000_110: op = OP_OR;    10'b0000000_111: op = OP_AND;
        default:         op = OP_NOP;
      endcase
      7'b0010011: case (ir[14:12])
        3'b000: op = OP_ADDI;   3'b010: op = OP_SLTI;
        3'b011: op = OP_SLTIU;  3'b100: op = OP_XORI;
        3'b110: op = OP_ORI;    3'b111: op = OP_ANDI;
        3'b001: op = (ir[31:25] == 7'b0000000) ? OP_SLLI : OP_NOP;
        default: op = (ir[31:25] == 7'b0000000) ? OP_SRLI :
                      (ir[31:25] == 7'b0100000) ? OP_SRAI : OP_NOP;
      endcase
      7'b0000011: case (ir[14:12])
        3'b000: op = OP_LB;   3'b001: op = OP_LH;  3'b010: op = OP_LW;
        3'b100: op = OP_LBU;  3'b101: op = OP_LHU; default: op = OP_NOP;
      endcase
      7'b0100011: case (ir[14:12])
        3'b000: op = OP_SB;  3'b001: op = OP_SH;  3'b010: op = OP_SW;
        default: op = OP_NOP;
      endcase
      7'b1100011: case (ir[14:12])
        3'b000: op = OP_BEQ;  3'b001: op = OP_BNE;  3'b100: op = OP_BLT;
        3'b101: op = OP_BGE;  3'b110: op = OP_BLTU; 3'b111: op = OP_BGEU;
        default: op = OP_NOP;
      endcase
      7'b0110111: op = OP_LUI;
      7'b0010111: op = OP_AUIPC;
      7'b1101111: op = OP_JAL;
      7'b1100111: op = (ir[14:12] == 3'b000) ? OP_JALR : OP_NOP;
      7'b0001111: op = (ir[14:12] == 3'b000) ? OP_FENCE : OP_NOP;
      7'b1110011: begin
        if (ir == 32'h0000_0073)      op = OP_ECALL;
        else if (ir == 32'h0010_0073) op = OP_EBREAK;
        else case (ir[14:12])
          3'b001: op = OP_CSRRW;   3'b010: op = OP_CSRRS;   3'b011: op = OP_CSRRC;
          3'b101: op = OP_CSRRWI;  3'b110: op = OP_CSRRSI;  3'b111: op = OP_CSRRCI;
          default: op = OP_NOP;
        endcase
      end
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

  // Build the control bundle: register fields used and immediate format.
  function automatic Signal signal_of(input op_e op);
    Signal s;
    s    = IR_SIGNAL_NOP;
    s.op = op;
    if (op inside {OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
                   OP_OR, OP_AND, OP_ECALL}) begin
      s.rs1 = 1'b1; s.rs2 = 1'b1; s.rDinSrc = 1'b1;
    end else if (op inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
                            OP_SLLI, OP_SRLI, OP_SRAI, OP_LB, OP_LH, OP_LW, OP_LBU,
                            OP_LHU, OP_JALR, OP_CSRRW, OP_CSRRS, OP_CSRRC}) begin
      s.rs1 = 1'b1; s.rDinSrc = 1'b1; s.imm_sel = IMM_I;
    end else if (op inside {OP_SB, OP_SH, OP_SW}) begin
      s.rs1 = 1'b1; s.rs2 = 1'b1; s.imm_sel = IMM_S;
    end else if (op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU}) begin
      s.rs1 = 1'b1; s.rs2 = 1'b1; s.imm_sel = IMM_B;
    end else if (op inside {OP_LUI, OP_AUIPC}) begin
      s.rDinSrc = 1'b1; s.imm_sel = IMM_U;
    end else if (op == OP_JAL) begin
      s.rDinSrc = 1'b1; s.imm_sel = IMM_J;
    end else if (op inside {OP_CSRRWI, OP_CSRRSI, OP_CSRRCI}) begin
      // The rs1 field holds a 5-bit immediate (uimm), not a register index.
      s.rDinSrc = 1'b1; s.imm_sel = IMM_I;
    end
    return s;
  endfunction

  // Handshake and routing. A push goes straight to the output register when nothing is queued ahead of it.
  always_comb begin
    w_push       = in_valid & in_ready & ~flush;
    w_out_free   = ~out_valid | out_ready;
    w_empty      = (count == '0);
    w_pop        = ~w_empty & w_out_free;
    w_bypass     = w_empty & w_out_free & w_push;
    w_fifo_wr    = w_push & ~w_bypass;
    w_load       = w_pop | w_bypass;
    w_ld_pc      = w_pop ? r_pc_mem[r_rptr] : in_pc;
    w_ld_ir      = w_pop ? r_ir_mem[r_rptr] : in_ir;
    w_count_next = count + CNT_W'(w_fifo_wr) - CNT_W'(w_pop);
  end

  // Decode the word that is entering the output register.
  always_comb begin
    w_op    = match_op(w_ld_ir[31:0]);
    w_sig   = signal_of(w_op);
    w_ecall = (w_op == OP_ECALL);
    w_rs1   = w_sig.rs1     ? (w_ecall ? 5'd17 : w_ld_ir[19:15]) : 5'd0;
    w_rs2   = w_sig.rs2     ? (w_ecall ? 5'd10 : w_ld_ir[24:20]) : 5'd0;
    w_rd    = w_sig.rDinSrc ? (w_ecall ? 5'd11 : w_ld_ir[11:7])  : 5'd0;
    case (w_sig.imm_sel)
      IMM_I:   w_imm = {{(WIDTH-12){w_ld_ir[31]}}, w_ld_ir[31:20]};
      IMM_S:   w_imm = {{(WIDTH-12){w_ld_ir[31]}}, w_ld_ir[31:25], w_ld_ir[11:7]};
      IMM_B:   w_imm = {{(WIDTH-12){w_ld_ir[31]}}, w_ld_ir[31], w_ld_ir[7],
                        w_ld_ir[30:25], w_ld_ir[11:8]};
      IMM_U:   w_imm = {{(WIDTH-20){w_ld_ir[31]}}, w_ld_ir[31:12]};
      IMM_J:   w_imm = {{(WIDTH-20){w_ld_ir[31]}}, w_ld_ir[31], w_ld_ir[19:12],
                        w_ld_ir[20], w_ld_ir[30:21]};
      default: w_imm = '0;
    endcase
  end

  // Queue storage. It has no reset because the pointers and count decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_fifo_wr) begin
      r_pc_mem[r_wptr] <= in_pc;
      r_ir_mem[r_wptr] <= in_ir;
    end
  end

  // Pointers, occupancy and registered in_ready. Reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      if (w_fifo_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      count    <= w_count_next;
      in_ready <= (w_count_next != C_FULL);
    end
  end

  // Decoded output register. It holds its value while execute stalls, and a flush only drops out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      imm       <= '0;
      signal    <= IR_SIGNAL_NOP;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_load) begin
      out_valid <= 1'b1;
      out_pc    <= w_ld_pc;
      rs1       <= w_rs1;
      rs2       <= w_rs2;
      rd        <= w_rd;
      imm       <= w_imm;
      signal    <= w_sig;
      illegal   <= (w_op == OP_NOP);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_queue.sv
// ============================================================================
// Module   : tb_decode_queue
// Brief    : Self-checking bench for decode_queue. The reference model is a
//            mask/match instruction table plus a queue of the accepted words.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int TW    = WIDTH + 15 + WIDTH + $bits(Signal) + 1;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [WIDTH-1:0] in_pc, in_ir, out_pc, imm;
  logic [4:0]       rs1, rs2, rd;
  Signal            signal;
  logic [CW-1:0]    count;

  decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ir(in_ir), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .signal(signal),
    .illegal(illegal), .count(count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    op_e         op;
    byte         fmt;
  } ent_t;
  ent_t tab[$];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } pair_t;
  pair_t exp_q[$];

  logic [TW-1:0] dut_t;
  assign dut_t = {out_pc, rs1, rs2, rd, imm, signal, illegal};

  function automatic void add(input logic [31:0] m, input logic [31:0] v, input op_e op, input byte f);
    ent_t e;
    e.mask = m; e.match = v; e.op = op; e.fmt = f;
    tab.push_back(e);
  endfunction

  // Instruction table in priority order. Format letters: R, I, S, B, U, J; E = ecall,
  // K = CSR immediate form, N = no operands.
  task automatic init_table();
    add(32'hFE00707F, 32'h00000033, OP_ADD, "R");   add(32'hFE00707F, 32'h40000033, OP_SUB, "R");
    add(32'hFE00707F, 32'h00001033, OP_SLL, "R");   add(32'hFE00707F, 32'h00002033, OP_SLT, "R");
    add(32'hFE00707F, 32'h00003033, OP_SLTU, "R");  add(32'hFE00707F, 32'h00004033, OP_XOR, "R");
    add(32'hFE00707F, 32'h00005033, OP_SRL, "R");   add(32'hFE00707F, 32'h40005033, OP_SRA, "R");
    add(32'hFE00707F, 32'h00006033, OP_OR, "R");    add(32'hFE00707F, 32'h00007033, OP_AND, "R");
    add(32'h0000707F, 32'h00000013, OP_ADDI, "I");  add(32'h0000707F, 32'h00002013, OP_SLTI, "I");
    add(32'h0000707F, 32'h00003013, OP_SLTIU, "I"); add(32'h0000707F, 32'h00004013, OP_XORI, "I");
    add(32'h0000707F, 32'h00006013, OP_ORI, "I");   add(32'h0000707F, 32'h00007013, OP_ANDI, "I");
    add(32'hFE00707F, 32'h00001013, OP_SLLI, "I");  add(32'hFE00707F, 32'h00005013, OP_SRLI, "I");
    add(32'hFE00707F, 32'h40005013, OP_SRAI, "I");
    add(32'h0000707F, 32'h00000003, OP_LB, "I");    add(32'h0000707F, 32'h00001003, OP_LH, "I");
    add(32'h0000707F, 32'h00002003, OP_LW, "I");    add(32'h0000707F, 32'h00004003, OP_LBU, "I");
    add(32'h0000707F, 32'h00005003, OP_LHU, "I");
    add(32'h0000707F, 32'h00000023, OP_SB, "S");    add(32'h0000707F, 32'h00001023, OP_SH, "S");
    add(32'h0000707F, 32'h00002023, OP_SW, "S");
    add(32'h0000707F, 32'h00000063, OP_BEQ, "B");   add(32'h0000707F, 32'h00001063, OP_BNE, "B");
    add(32'h0000707F, 32'h00004063, OP_BLT, "B");   add(32'h0000707F, 32'h00005063, OP_BGE, "B");
    add(32'h0000707F, 32'h00006063, OP_BLTU, "B");  add(32'h0000707F, 32'h00007063, OP_BGEU, "B");
    add(32'h0000007F, 32'h00000037, OP_LUI, "U");   add(32'h0000007F, 32'h00000017, OP_AUIPC, "U");
    add(32'h0000007F, 32'h0000006F, OP_JAL, "J");   add(32'h0000707F, 32'h00000067, OP_JALR, "I");
    add(32'h0000707F, 32'h0000000F, OP_FENCE, "N");
    add(32'hFFFFFFFF, 32'h00000073, OP_ECALL, "E"); add(32'hFFFFFFFF, 32'h00100073, OP_EBREAK, "N");
    add(32'h0000707F, 32'h00001073, OP_CSRRW, "I"); add(32'h0000707F, 32'h00002073, OP_CSRRS, "I");
    add(32'h0000707F, 32'h00003073, OP_CSRRC, "I"); add(32'h0000707F, 32'h00005073, OP_CSRRWI, "K");
    add(32'h0000707F, 32'h00006073, OP_CSRRSI, "K"); add(32'h0000707F, 32'h00007073, OP_CSRRCI, "K");
  endtask

  // Reference decode: take the first table hit and derive the fields from its format letter.
  function automatic logic [TW-1:0] model(input pair_t p);
    logic [31:0] ir;
    logic        hit, u1, u2, ud;
    byte         f;
    Signal       s;
    logic [4:0]  r1, r2, rdv;
    logic [31:0] iv;
    logic [11:0] b12;
    logic [19:0] j20;
    ir = p.ir; hit = 1'b0; f = "X";
    s = IR_SIGNAL_NOP;
    foreach (tab[i]) begin
      if (!hit && ((ir & tab[i].mask) == tab[i].match)) begin
        hit = 1'b1; s.op = tab[i].op; f = tab[i].fmt;
      end
    end
    u1 = (f == "R" || f == "I" || f == "S" || f == "B" || f == "E");
    u2 = (f == "R" || f == "S" || f == "B" || f == "E");
    ud = (f == "R" || f == "I" || f == "U" || f == "J" || f == "E" || f == "K");
    s.rs1 = u1; s.rs2 = u2; s.rDinSrc = ud;
    r1  = u1 ? ((f == "E") ? 5'd17 : ir[19:15]) : 5'd0;
    r2  = u2 ? ((f == "E") ? 5'd10 : ir[24:20]) : 5'd0;
    rdv = ud ? ((f == "E") ? 5'd11 : ir[11:7])  : 5'd0;
    b12 = {ir[31], ir[7], ir[30:25], ir[11:8]};
    j20 = {ir[31], ir[19:12], ir[20], ir[30:21]};
    iv  = 32'd0;
    case (f)
      "I", "K": begin s.imm_sel = IMM_I; iv = {{20{ir[31]}}, ir[31:20]}; end
      "S":      begin s.imm_sel = IMM_S; iv = {{20{ir[31]}}, ir[31:25], ir[11:7]}; end
      "B":      begin s.imm_sel = IMM_B; iv = {{20{b12[11]}}, b12}; end
      "U":      begin s.imm_sel = IMM_U; iv = {{12{ir[31]}}, ir[31:12]}; end
      "J":      begin s.imm_sel = IMM_J; iv = {{12{j20[19]}}, j20}; end
      default:  s.imm_sel = IMM_NONE;
    endcase
    return {p.pc, r1, r2, rdv, iv, s, ~hit};
  endfunction

  // Mostly legal words built from a random table entry, plus about 1 in 8 fully random words.
  function automatic logic [31:0] gen_word();
    int k;
    if ($urandom_range(0, 7) == 0) return $urandom;
    k = $urandom_range(0, tab.size() - 1);
    return ($urandom & ~tab[k].mask) | tab[k].match;
  endfunction

  function automatic logic [31:0] next_pc();
    pc_ctr = pc_ctr + 32'd4;
    return pc_ctr;
  endfunction

  // Advance one clock. Before the edge, record what execute takes (and the model's
  // expected value for it) and update the model queue.
  task automatic step(output logic took, output logic [TW-1:0] got, output logic [TW-1:0] exp);
    took = 1'b0; got = '0; exp = '0;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        took = 1'b1;
        got  = dut_t;
        // If the model has nothing queued, make the expected value differ from got so the check fails.
        exp  = (exp_q.size() > 0) ? model(exp_q.pop_front()) : ~dut_t;
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back({in_pc, in_ir});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic tk; logic [TW-1:0] g, e;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_ir = '0;
    repeat (3) step(tk, g, e);
    rst = 1'b0;
    checks++;
    if ({out_valid, in_ready, count} !== {1'b0, 1'b1, CW'(0)})
      $display("FAIL reset_ctrl: got valid/ready/count %b/%b/%0d want 0/1/0", out_valid, in_ready, count);
    checks++;
    if ({out_pc, rs1, rs2, rd, imm, illegal} !== '0)
      $display("FAIL reset_data: got %h want 0", {out_pc, rs1, rs2, rd, imm, illegal});
    checks++;
    if (signal !== IR_SIGNAL_NOP)
      $display("FAIL reset_signal: got %h want %h", signal, IR_SIGNAL_NOP);
    failures += (({out_valid, in_ready, count} !== {1'b0, 1'b1, CW'(0)}) ? 1 : 0)
              + (({out_pc, rs1, rs2, rd, imm, illegal} !== '0) ? 1 : 0)
              + ((signal !== IR_SIGNAL_NOP) ? 1 : 0);
  endtask

  task automatic test_addi();
    logic tk; logic [TW-1:0] g, e;
    out_ready = 1'b0; in_valid = 1'b1; in_pc = next_pc(); in_ir = 32'hFFF00293;
    step(tk, g, e);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, rd, rs1, imm} !== {1'b1, 5'd5, 5'd0, 32'hFFFFFFFF}) begin
      failures++;
      $display("FAIL addi_fields: got v=%b rd=%0d rs1=%0d imm=%h want v=1 rd=5 rs1=0 imm=ffffffff",
               out_valid, rd, rs1, imm);
    end
    checks++;
    if (illegal !== 1'b0 || signal.op !== OP_ADDI) begin
      failures++;
      $display("FAIL addi_signal: got op=%0d illegal=%b want op=%0d illegal=0", signal.op, illegal, OP_ADDI);
    end
    out_ready = 1'b1;
    step(tk, g, e);
    out_ready = 1'b0;
    checks++;
    if (!tk || g !== e || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL addi_consume: took=%b got %h want %h valid_after=%b", tk, g, e, out_valid);
    end
  endtask

  task automatic test_fill_drain();
    logic tk; logic [TW-1:0] g, e, held;
    out_ready = 1'b0;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_pc = next_pc(); in_ir = gen_word();
      step(tk, g, e);
      if (i == 0) held = dut_t;
    end
    // A sixth offer while full must be refused.
    in_pc = next_pc(); in_ir = gen_word();
    step(tk, g, e);
    in_valid = 1'b0;
    checks++;
    if ({count, in_ready, out_valid} !== {CW'(DEPTH), 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL full_state: got count=%0d ready=%b valid=%b want %0d/0/1", count, in_ready, out_valid, DEPTH);
    end
    checks++;
    if (dut_t !== held) begin
      failures++;
      $display("FAIL hold_stable: got %h want %h", dut_t, held);
    end
    out_ready = 1'b1;
    step(tk, g, e);
    checks++;
    if (!tk || g !== e) begin
      failures++;
      $display("FAIL drain_first: took=%b got %h want %h", tk, g, e);
    end
    checks++;
    if ({count, in_ready} !== {CW'(DEPTH-1), 1'b1}) begin
      failures++;
      $display("FAIL ready_after_pop: got count=%0d ready=%b want %0d/1", count, in_ready, DEPTH-1);
    end
    for (int n = 0; n < 20 && out_valid; n++) begin
      step(tk, g, e);
      if (tk) begin
        checks++;
        if (g !== e) begin failures++; $display("FAIL drain_order: got %h want %h", g, e); end
      end
    end
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_done: got valid=%b pending=%0d want 0/0", out_valid, exp_q.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic test_ecall();
    logic tk; logic [TW-1:0] g, e;
    out_ready = 1'b0; in_valid = 1'b1; in_pc = next_pc(); in_ir = 32'h00000073;
    step(tk, g, e);
    in_valid = 1'b0;
    checks++;
    if ({rs1, rs2, rd, illegal, out_valid} !== {5'd17, 5'd10, 5'd11, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL ecall_regs: got rs1=%0d rs2=%0d rd=%0d ill=%b v=%b want 17/10/11/0/1",
               rs1, rs2, rd, illegal, out_valid);
    end
    out_ready = 1'b1;
    step(tk, g, e);
    out_ready = 1'b0;
    checks++;
    if (!tk || g !== e) begin failures++; $display("FAIL ecall_model: got %h want %h", g, e); end
  endtask

  task automatic test_illegal();
    logic tk; logic [TW-1:0] g, e;
    out_ready = 1'b0; in_valid = 1'b1; in_pc = next_pc(); in_ir = 32'hFFFFFFFF;
    step(tk, g, e);
    in_valid = 1'b0;
    checks++;
    if ({signal, illegal, out_valid, rs1, rs2, rd, imm} !==
        {IR_SIGNAL_NOP, 1'b1, 1'b1, 15'd0, 32'd0}) begin
      failures++;
      $display("FAIL illegal_word: got sig=%h ill=%b v=%b want sig=%h ill=1 v=1", signal, illegal, out_valid, IR_SIGNAL_NOP);
    end
    out_ready = 1'b1;
    step(tk, g, e);
    out_ready = 1'b0;
    checks++;
    if (!tk || g !== e) begin failures++; $display("FAIL illegal_model: got %h want %h", g, e); end
  endtask

  task automatic test_flush();
    logic tk; logic [TW-1:0] g, e;
    logic [31:0] fresh_pc;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_pc = next_pc(); in_ir = gen_word();
      step(tk, g, e);
    end
    flush = 1'b1; in_pc = next_pc(); in_ir = gen_word();
    step(tk, g, e);
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if ({count, out_valid, in_ready} !== {CW'(0), 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL flush_state: got count=%0d valid=%b ready=%b want 0/0/1", count, out_valid, in_ready);
    end
    fresh_pc = pc_ctr + 32'd4;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = next_pc(); in_ir = gen_word();
      step(tk, g, e);
      if (tk) begin
        checks++;
        if (g !== e) begin failures++; $display("FAIL flush_after: got %h want %h", g, e); end
      end
    end
    in_valid = 1'b0;
    for (int n = 0; n < 10 && out_valid; n++) begin
      checks++;
      if (out_pc < fresh_pc) begin
        failures++;
        $display("FAIL flush_stale: got pc %h want >= %h", out_pc, fresh_pc);
      end
      step(tk, g, e);
      if (tk) begin
        checks++;
        if (g !== e) begin failures++; $display("FAIL flush_drain: got %h want %h", g, e); end
      end
    end
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL flush_done: got valid=%b pending=%0d want 0/0", out_valid, exp_q.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic tk; logic [TW-1:0] g, e;
    int taken;
    taken = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_pc = next_pc(); in_ir = gen_word();
      step(tk, g, e);
      if (tk) begin
        taken++;
        checks++;
        if (g !== e) begin failures++; $display("FAIL b2b_data: got %h want %h", g, e); end
      end
      checks++;
      if ({out_valid, count, in_ready} !== {1'b1, CW'(0), 1'b1}) begin
        failures++;
        $display("FAIL b2b_rate: cycle %0d got v=%b count=%0d ready=%b want 1/0/1", i, out_valid, count, in_ready);
      end
    end
    in_valid = 1'b0;
    step(tk, g, e);
    if (tk) begin
      taken++;
      checks++;
      if (g !== e) begin failures++; $display("FAIL b2b_last: got %h want %h", g, e); end
    end
    checks++;
    if (taken != 20) begin failures++; $display("FAIL b2b_count: got %0d words want 20", taken); end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic tk; logic [TW-1:0] g, e;
    int sz;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      in_pc     = next_pc();
      in_ir     = gen_word();
      step(tk, g, e);
      if (tk) begin
        checks++;
        if (g !== e) begin failures++; $display("FAIL rand_data: cycle %0d got %h want %h", i, g, e); end
      end
      sz = exp_q.size();
      checks++;
      if ({out_valid, count, in_ready} !==
          {(sz > 0), CW'((sz > 0) ? sz - 1 : 0), ((sz > 0 ? sz - 1 : 0) != DEPTH)}) begin
        failures++;
        $display("FAIL rand_occupancy: cycle %0d got v=%b count=%0d ready=%b model held %0d",
                 i, out_valid, count, in_ready, sz);
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 20 && out_valid; n++) begin
      step(tk, g, e);
      if (tk) begin
        checks++;
        if (g !== e) begin failures++; $display("FAIL rand_drain: got %h want %h", g, e); end
      end
    end
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rand_done: got valid=%b pending=%0d want 0/0", out_valid, exp_q.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic tk; logic [TW-1:0] g, e;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = next_pc(); in_ir = gen_word();
      step(tk, g, e);
    end
    rst = 1'b1; flush = 1'b1;
    step(tk, g, e);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready, count, out_pc, rs1, rs2, rd, imm, signal, illegal} !==
        {1'b0, 1'b1, CW'(0), 32'd0, 15'd0, 32'd0, IR_SIGNAL_NOP, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid: got v=%b ready=%b count=%0d pc=%h imm=%h sig=%h want full reset values",
               out_valid, in_ready, count, out_pc, imm, signal);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    init_table();
    #1;
    test_reset();
    test_addi();
    test_fill_drain();
    test_ecall();
    test_illegal();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
